// File: rtl/mem_stage.sv
// MIPS M stage: data-memory req/ack access, load extension and the M/W register.
// Optional access timeout/abort is enabled by defining DM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ins,
  input  logic [31:0] M_alu_res,
  input  logic [31:0] M_reg_rs,
  input  logic [31:0] M_reg_rt,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        m_stall,
  output logic        m_addr_err,
  output logic        m_timeout,
  output logic [31:0] W_PC,
  output logic [31:0] W_ins,
  output logic [31:0] W_alu_res,
  output logic [31:0] W_reg_rs,
  output logic [31:0] W_reg_rt,
  output logic [31:0] W_mem_read
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state_q, state_d;
  logic        is_load_s, is_store_s, uns_s, misalign_s, mem_op_s, abort_s;
  logic [1:0]  size_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;
  logic [31:0] w_pc_q, w_ins_q, w_alu_q, w_rs_q, w_rt_q, w_mr_q;
  logic [31:0] w_pc_d, w_ins_d, w_alu_d, w_rs_d, w_rt_d, w_mr_d;

  // Opcode decode and alignment check
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    uns_s      = 1'b0;
    size_s     = SZ_WORD;
    case (M_ins[31:26])
      6'h20: begin is_load_s = 1'b1; size_s = SZ_BYTE; end
      6'h21: begin is_load_s = 1'b1; size_s = SZ_HALF; end
      6'h23: begin is_load_s = 1'b1; size_s = SZ_WORD; end
      6'h24: begin is_load_s = 1'b1; size_s = SZ_BYTE; uns_s = 1'b1; end
      6'h25: begin is_load_s = 1'b1; size_s = SZ_HALF; uns_s = 1'b1; end
      6'h28: begin is_store_s = 1'b1; size_s = SZ_BYTE; end
      6'h29: begin is_store_s = 1'b1; size_s = SZ_HALF; end
      6'h2b: begin is_store_s = 1'b1; size_s = SZ_WORD; end
      default: begin is_load_s = 1'b0; is_store_s = 1'b0; end
    endcase
    misalign_s = (is_load_s | is_store_s) &
                 (((size_s == SZ_HALF) & M_alu_res[0]) |
                  ((size_s == SZ_WORD) & (M_alu_res[1:0] != 2'b00)));
    mem_op_s   = (is_load_s | is_store_s) & ~misalign_s;
  end

`ifdef DM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  assign abort_s   = (state_q == BUSY) & (cnt_q == CW'(TIMEOUT)) & ~dm_ack;
  assign m_timeout = timeout_q;

  // Wait counter: cleared on entry to BUSY, saturates at TIMEOUT
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | abort_s;
    if ((state_q == IDLE) && (state_d == BUSY)) begin
      cnt_d = {CW{1'b0}};
    end else if ((state_q == BUSY) && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timeout counter and sticky abort flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= {CW{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign abort_s   = 1'b0;
  assign m_timeout = 1'b0;
`endif

  // reset gates the handshake so dm_req drops the moment reset asserts
  assign dm_req     = reset & mem_op_s & ~abort_s;
  assign m_stall    = reset & mem_op_s & ~dm_ack & ~abort_s;
  assign m_addr_err = misalign_s;
  assign dm_we      = is_store_s & mem_op_s;
  assign dm_addr    = {M_alu_res[31:2], 2'b00};

  // Store lane steering and byte enables
  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = 32'h0000_0000;
    if (is_load_s) begin
      dm_be = 4'b1111;
    end else if (is_store_s) begin
      case (size_s)
        SZ_BYTE: begin
          dm_be    = 4'b0001 << M_alu_res[1:0];
          dm_wdata = {4{M_reg_rt[7:0]}};
        end
        SZ_HALF: begin
          dm_be    = M_alu_res[1] ? 4'b1100 : 4'b0011;
          dm_wdata = {2{M_reg_rt[15:0]}};
        end
        default: begin
          dm_be    = 4'b1111;
          dm_wdata = M_reg_rt;
        end
      endcase
    end else begin
      dm_be = 4'b0000;
    end
  end

  // Load lane select and extension
  always_comb begin
    case (M_alu_res[1:0])
      2'd0:    byte_s = dm_rdata[7:0];
      2'd1:    byte_s = dm_rdata[15:8];
      2'd2:    byte_s = dm_rdata[23:16];
      default: byte_s = dm_rdata[31:24];
    endcase
    half_s = M_alu_res[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_s)
      SZ_BYTE: ext_s = uns_s ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: ext_s = uns_s ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default: ext_s = dm_rdata;
    endcase
  end

  // Next state and M/W register contents (bubble while stalled)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_op_s && !dm_ack) state_d = BUSY;
        else                     state_d = IDLE;
      end
      BUSY: begin
        if (dm_ack || abort_s || !mem_op_s) state_d = IDLE;
        else                                state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase

    if (m_stall) begin
      w_pc_d  = 32'h0000_0000;
      w_ins_d = 32'h0000_0000;
      w_alu_d = 32'h0000_0000;
      w_rs_d  = 32'h0000_0000;
      w_rt_d  = 32'h0000_0000;
      w_mr_d  = 32'h0000_0000;
    end else begin
      w_pc_d  = M_PC;
      w_ins_d = M_ins;
      w_alu_d = M_alu_res;
      w_rs_d  = M_reg_rs;
      w_rt_d  = M_reg_rt;
      w_mr_d  = (is_load_s && mem_op_s && dm_ack) ? ext_s : 32'h0000_0000;
    end
  end

  // FSM state and M/W pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      w_pc_q  <= 32'h0000_0000;
      w_ins_q <= 32'h0000_0000;
      w_alu_q <= 32'h0000_0000;
      w_rs_q  <= 32'h0000_0000;
      w_rt_q  <= 32'h0000_0000;
      w_mr_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      w_pc_q  <= w_pc_d;
      w_ins_q <= w_ins_d;
      w_alu_q <= w_alu_d;
      w_rs_q  <= w_rs_d;
      w_rt_q  <= w_rt_d;
      w_mr_q  <= w_mr_d;
    end
  end

  assign W_PC       = w_pc_q;
  assign W_ins      = w_ins_q;
  assign W_alu_res  = w_alu_q;
  assign W_reg_rs   = w_rs_q;
  assign W_reg_rt   = w_rt_q;
  assign W_mem_read = w_mr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; expected M/W contents go through a scoreboard queue.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC, M_ins, M_alu_res, M_reg_rs, M_reg_rt;
  logic        dm_req, dm_we, dm_ack, m_stall, m_addr_err, m_timeout;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic [31:0] W_PC, W_ins, W_alu_res, W_reg_rs, W_reg_rt, W_mem_read;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc, ins, alu, rs, rt, mr;
  } wrec_t;
  wrec_t exp_q[$];

  localparam logic [31:0] I_LW  = 32'h8C43_0000;
  localparam logic [31:0] I_LB  = 32'h8043_0000;
  localparam logic [31:0] I_LH  = 32'h8443_0000;
  localparam logic [31:0] I_LBU = 32'h9043_0000;
  localparam logic [31:0] I_LHU = 32'h9443_0000;
  localparam logic [31:0] I_SB  = 32'hA043_0000;
  localparam logic [31:0] I_SH  = 32'hA443_0000;
  localparam logic [31:0] I_ADD = 32'h0022_1820;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .M_PC(M_PC), .M_ins(M_ins), .M_alu_res(M_alu_res), .M_reg_rs(M_reg_rs), .M_reg_rt(M_reg_rt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .m_stall(m_stall), .m_addr_err(m_addr_err), .m_timeout(m_timeout),
    .W_PC(W_PC), .W_ins(W_ins), .W_alu_res(W_alu_res), .W_reg_rs(W_reg_rs),
    .W_reg_rt(W_reg_rt), .W_mem_read(W_mem_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] rt, input logic ack, input logic [31:0] rdata);
    M_PC      = pc;
    M_ins     = ins;
    M_alu_res = alu;
    M_reg_rs  = pc ^ 32'hA5A5_0000;
    M_reg_rt  = rt;
    dm_ack    = ack;
    dm_rdata  = rdata;
    #3;
  endtask

  task automatic tick(input logic exp_stall, input logic [31:0] exp_mr);
    wrec_t e;
    wrec_t g;
    if (exp_stall) e = '0;
    else           e = {M_PC, M_ins, M_alu_res, M_reg_rs, M_reg_rt, exp_mr};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("w_pc", W_PC, g.pc);
    chk("w_ins", W_ins, g.ins);
    chk("w_alu_res", W_alu_res, g.alu);
    chk("w_reg_rs", W_reg_rs, g.rs);
    chk("w_reg_rt", W_reg_rt, g.rt);
    chk("w_mem_read", W_mem_read, g.mr);
  endtask

  initial begin
    reset = 1'b0;
    M_PC = 32'h0; M_ins = 32'h0; M_alu_res = 32'h0; M_reg_rs = 32'h0; M_reg_rt = 32'h0;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_pc", W_PC, 32'h0);
    chk("rst_w_mem_read", W_mem_read, 32'h0);
    chk("rst_req", {31'h0, dm_req}, 32'h0);
    chk("rst_stall", {31'h0, m_stall}, 32'h0);
    chk("rst_timeout", {31'h0, m_timeout}, 32'h0);
    reset = 1'b1;

    // non-memory op: one cycle through
    set_in(32'h400, I_ADD, 32'h1234, 32'h77, 1'b0, 32'h0);
    chk("alu_stall", {31'h0, m_stall}, 32'h0);
    chk("alu_req", {31'h0, dm_req}, 32'h0);
    chk("alu_err", {31'h0, m_addr_err}, 32'h0);
    tick(1'b0, 32'h0);

    // lw 0x100, two wait cycles
    set_in(32'h404, I_LW, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("lw_stall0", {31'h0, m_stall}, 32'h1);
    chk("lw_req0", {31'h0, dm_req}, 32'h1);
    chk("lw_addr", dm_addr, 32'h100);
    chk("lw_be", {28'h0, dm_be}, 32'hF);
    chk("lw_we", {31'h0, dm_we}, 32'h0);
    tick(1'b1, 32'h0);
    set_in(32'h404, I_LW, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("lw_stall1", {31'h0, m_stall}, 32'h1);
    tick(1'b1, 32'h0);
    set_in(32'h404, I_LW, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("lw_stall_ack", {31'h0, m_stall}, 32'h0);
    chk("lw_req_ack", {31'h0, dm_req}, 32'h1);
    tick(1'b0, 32'hDEADBEEF);

    // back-to-back zero-wait loads with extension
    set_in(32'h408, I_LB, 32'h103, 32'h0, 1'b1, 32'h80112233);
    chk("lb_req", {31'h0, dm_req}, 32'h1);
    tick(1'b0, 32'hFFFFFF80);
    set_in(32'h40C, I_LBU, 32'h103, 32'h0, 1'b1, 32'h80112233);
    tick(1'b0, 32'h00000080);
    set_in(32'h410, I_LH, 32'h102, 32'h0, 1'b1, 32'h80017FFF);
    tick(1'b0, 32'hFFFF8001);
    set_in(32'h414, I_LHU, 32'h100, 32'h0, 1'b1, 32'h8001F00D);
    tick(1'b0, 32'h0000F00D);

    // stores
    set_in(32'h418, I_SH, 32'h202, 32'h1234ABCD, 1'b1, 32'h0);
    chk("sh_be", {28'h0, dm_be}, 32'hC);
    chk("sh_wdata", dm_wdata, 32'hABCDABCD);
    chk("sh_addr", dm_addr, 32'h200);
    chk("sh_we", {31'h0, dm_we}, 32'h1);
    chk("sh_stall", {31'h0, m_stall}, 32'h0);
    tick(1'b0, 32'h0);
    set_in(32'h41C, I_SB, 32'h101, 32'h000000A5, 1'b1, 32'h0);
    chk("sb_be", {28'h0, dm_be}, 32'h2);
    chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    tick(1'b0, 32'h0);

    // misaligned lw suppressed
    set_in(32'h420, I_LW, 32'h101, 32'h0, 1'b0, 32'h12345678);
    chk("mis_req", {31'h0, dm_req}, 32'h0);
    chk("mis_err", {31'h0, m_addr_err}, 32'h1);
    chk("mis_stall", {31'h0, m_stall}, 32'h0);
    tick(1'b0, 32'h0);

    // stray ack on non-memory op ignored
    set_in(32'h424, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF);
    chk("stray_req", {31'h0, dm_req}, 32'h0);
    tick(1'b0, 32'h0);

    // async reset while BUSY
    set_in(32'h500, I_LW, 32'h300, 32'h0, 1'b0, 32'h0);
    tick(1'b1, 32'h0);
    set_in(32'h500, I_LW, 32'h300, 32'h0, 1'b0, 32'h0);
    chk("busy_req", {31'h0, dm_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_req", {31'h0, dm_req}, 32'h0);
    chk("arst_stall", {31'h0, m_stall}, 32'h0);
    set_in(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    chk("arst_w_pc", W_PC, 32'h0);
    chk("arst_w_ins", W_ins, 32'h0);
    reset = 1'b1;
    set_in(32'h504, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF);
    chk("late_ack_req", {31'h0, dm_req}, 32'h0);
    tick(1'b0, 32'h0);
    set_in(32'h508, I_LW, 32'h300, 32'h0, 1'b1, 32'h0BADF00D);
    chk("post_rst_stall", {31'h0, m_stall}, 32'h0);
    tick(1'b0, 32'h0BADF00D);

`ifdef DM_TIMEOUT_EN
    // no ack: four stalled BUSY cycles, then abort
    set_in(32'h600, I_LW, 32'h104, 32'h0, 1'b0, 32'h0);
    chk("to_stall_idle", {31'h0, m_stall}, 32'h1);
    tick(1'b1, 32'h0);
    repeat (4) begin
      set_in(32'h600, I_LW, 32'h104, 32'h0, 1'b0, 32'h0);
      chk("to_stall_busy", {31'h0, m_stall}, 32'h1);
      tick(1'b1, 32'h0);
    end
    set_in(32'h600, I_LW, 32'h104, 32'h0, 1'b0, 32'h0);
    chk("to_abort_stall", {31'h0, m_stall}, 32'h0);
    chk("to_abort_req", {31'h0, dm_req}, 32'h0);
    tick(1'b0, 32'h0);
    chk("to_flag", {31'h0, m_timeout}, 32'h1);
    set_in(32'h604, I_ADD, 32'h55, 32'h0, 1'b0, 32'h0);
    chk("to_next_stall", {31'h0, m_stall}, 32'h0);
    tick(1'b0, 32'h0);
    chk("to_sticky", {31'h0, m_timeout}, 32'h1);
`else
    chk("no_timeout", {31'h0, m_timeout}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
